// File: rtl/keyscan_pkg.sv
// keyscan_pkg: shared constants, types and helpers for the 4x4 keypad scanner.
//   NUM_ROWS / NUM_COLS / KEY_W    : keypad geometry and width of the key vector
//   DEF_SCAN_DIV                   : default dwell length per column, in clk cycles
//   DEF_DEBOUNCE_SCANS             : default number of identical frames before psw updates
//   col_drive()                    : active-low one-hot column drive for a column index
package keyscan_pkg;

  localparam int NUM_ROWS           = 4;
  localparam int NUM_COLS           = 4;
  localparam int KEY_W              = NUM_ROWS * NUM_COLS;
  localparam int DEF_SCAN_DIV       = 1000;
  localparam int DEF_DEBOUNCE_SCANS = 8;

  typedef logic [KEY_W-1:0]    key_vec_t;
  typedef logic [NUM_COLS-1:0] col_vec_t;
  typedef logic [1:0]          col_idx_t;

  // Exactly one column low: the one currently being scanned.
  function automatic col_vec_t col_drive(input col_idx_t cidx);
    return ~(col_vec_t'(1) << cidx);
  endfunction

endpackage

// File: rtl/keyscan_if.sv
// keyscan_if: keypad-side signals of the scanner.
//   row     : keypad row lines, active-low (pulled up), asynchronous to clk
//   col     : column drive, active-low, exactly one bit low
//   psw     : debounced key state, bit (r*4+c) high = key (r,c) pressed
//   psw_chg : one-cycle pulse when psw takes a new, different value
// Modport slave is the scanner's view; master is the keypad/consumer view.
interface keyscan_if;
  import keyscan_pkg::*;

  logic [NUM_ROWS-1:0] row;
  col_vec_t            col;
  key_vec_t            psw;
  logic                psw_chg;

  modport slave (input row, output col, output psw, output psw_chg);
  modport master (output row, input col, input psw, input psw_chg);

endinterface

// File: rtl/keyscan_sync2.sv
// sync2: two-flop synchronizer for a bus of independent, slowly changing bits.
//   clk, rst : system clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (two clk cycles of latency)
// On reset both stages load RST_VAL so the output looks idle immediately.
module sync2 #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keyscan.sv
// keyscan: 4x4 keypad column scanner with frame-level debouncing.
//   clk, rst : system clock and synchronous active-high reset
//   kbus     : keyscan_if.slave -- row in, col / psw / psw_chg out
// Each column is driven low for SCAN_DIV cycles and the rows are sampled on
// the last dwell cycle. Four column samples make one frame; psw follows the
// frame once DEBOUNCE_SCANS consecutive frames are identical.
module keyscan
  import keyscan_pkg::*;
#(
  parameter int SCAN_DIV       = DEF_SCAN_DIV,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic      clk,
  input  logic      rst,
  keyscan_if.slave  kbus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_LOAD = SW'(DEBOUNCE_SCANS - 1);

  logic [NUM_ROWS-1:0] row_sync;

  logic [DW-1:0] dwell_reg;
  col_idx_t      cidx_reg;
  key_vec_t      frame_reg;
  key_vec_t      prev_reg;
  logic [SW-1:0] stable_reg;
  logic          load_reg;
  key_vec_t      psw_reg;
  logic          psw_chg_reg;

  logic          sample;
  logic          complete;
  col_vec_t      col_sel;
  key_vec_t      frame_next;
  logic          same;
  logic [SW-1:0] stable_inc;
  logic [SW-1:0] stable_next;
  logic          load_next;

  sync2 #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (kbus.row),
    .q   (row_sync)
  );

  // Sampling on the last dwell cycle gives the synchronizer and the keypad
  // lines the whole dwell period to settle after the column switches.
  assign sample   = (dwell_reg == DWELL_LAST);
  assign complete = sample && (cidx_reg == 2'd3);
  assign col_sel  = sample ? ~col_drive(cidx_reg) : '0;

  // Per row: replace the bit of the current column, keep the others.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign frame_next[gi*NUM_COLS +: NUM_COLS] =
          (col_sel & {NUM_COLS{~row_sync[gi]}}) |
          (~col_sel & frame_reg[gi*NUM_COLS +: NUM_COLS]);
    end
  endgenerate

  assign same       = (frame_next == prev_reg);
  assign stable_inc = (stable_reg == STABLE_MAX) ? stable_reg : stable_reg + 1'b1;

  always_comb begin
    stable_next = stable_reg;
    load_next   = 1'b0;
    if (complete) begin
      stable_next = same ? stable_inc : '0;
      // The DEBOUNCE_SCANS-th identical frame (counting the all-zero frame
      // before the first) is the one that takes the counter to DEBOUNCE_SCANS-1.
      if (DEBOUNCE_SCANS == 1) begin
        load_next = 1'b1;
      end else begin
        load_next = same && (stable_reg != STABLE_MAX) && (stable_inc == STABLE_LOAD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_reg   <= '0;
      cidx_reg    <= '0;
      frame_reg   <= '0;
      prev_reg    <= '0;
      stable_reg  <= '0;
      load_reg    <= 1'b0;
      psw_reg     <= '0;
      psw_chg_reg <= 1'b0;
    end else begin
      if (sample) begin
        dwell_reg <= '0;
        cidx_reg  <= cidx_reg + 2'd1;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end

      frame_reg  <= frame_next;
      stable_reg <= stable_next;
      load_reg   <= load_next;
      if (complete) begin
        prev_reg <= frame_next;
      end

      // prev_reg still holds the frame that qualified: the next completion
      // is at least 4*SCAN_DIV cycles away.
      if (load_reg) begin
        psw_reg     <= prev_reg;
        psw_chg_reg <= (prev_reg != psw_reg);
      end else begin
        psw_chg_reg <= 1'b0;
      end
    end
  end

  assign kbus.col     = col_drive(cidx_reg);
  assign kbus.psw     = psw_reg;
  assign kbus.psw_chg = psw_chg_reg;

endmodule

// File: tb/tb_keyscan.sv
// tb_keyscan: directed test of keyscan with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// A key-matrix model drives the rows from the pressed-key vector and the
// column drive. Each stimulus frame pushes the expected psw / psw_chg result
// to a queue; it is popped one cycle after that frame's final sample.
module tb_keyscan;
  import keyscan_pkg::*;

  localparam int SDIV  = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 4 * SDIV;

  typedef struct {
    logic [15:0] psw;
    logic        chg;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  row_drv;

  keyscan_if kif ();

  keyscan #(
    .SCAN_DIV       (SDIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .kbus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key shorts its row to the column currently driven low.
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_drv[r] = ~|(keys[r*4 +: 4] & ~kif.col);
    end
  end
  assign kif.row = row_drv;

  int          errors;
  int          checks;
  int          k;
  exp_t        sb[$];
  logic [15:0] hist[$];
  logic [15:0] psw_model;
  logic [15:0] cur_exp;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  // One clock; sample at the falling edge.
  task automatic tick();
    logic [3:0] col_exp;
    exp_t       e;
    @(posedge clk);
    @(negedge clk);
    k++;
    col_exp = 4'hF;
    col_exp[(k / SDIV) % 4] = 1'b0;
    check("col", 16'(kif.col), 16'(col_exp));
    if (k > 1 && (k % FRAME) == 1) begin
      if (sb.size() == 0) begin
        check("sb_empty", 16'(1), 16'(0));
      end else begin
        e = sb.pop_front();
        check("psw_upd", kif.psw, e.psw);
        check("chg_upd", 16'(kif.psw_chg), 16'(e.chg));
        cur_exp = e.psw;
        $display("frame result k=%0d psw=%h psw_chg=%0b expected psw=%h chg=%0b",
                 k, kif.psw, kif.psw_chg, e.psw, e.chg);
      end
    end else begin
      check("psw_hold", kif.psw, cur_exp);
      check("chg_idle", 16'(kif.psw_chg), 16'(0));
    end
  endtask

  // Hold a key pattern for one full frame; expected result: psw follows the
  // frame when the last DEB frames (including the all-zero frame before the
  // first one) are identical.
  task automatic run_frame(input logic [15:0] f);
    exp_t e;
    logic all_same;
    keys = f;
    hist.push_back(f);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_same = (hist.size() == DEB);
    for (int i = 1; i < hist.size(); i++) begin
      if (hist[i] != hist[0]) all_same = 1'b0;
    end
    e.psw = all_same ? f : psw_model;
    e.chg = (e.psw != psw_model);
    psw_model = e.psw;
    sb.push_back(e);
    repeat (FRAME) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_col", 16'(kif.col), 16'h000E);
    check("rst_psw", kif.psw, 16'h0000);
    check("rst_chg", 16'(kif.psw_chg), 16'(0));
    $display("reset psw=%h col=%b", kif.psw, kif.col);
    rst = 1'b0;
    k = 0;
    sb.delete();
    hist.delete();
    hist.push_back(16'h0000);
    psw_model = 16'h0000;
    cur_exp = 16'h0000;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    k = 0;
    keys = 16'h0000;
    rst = 1'b1;
    psw_model = 16'h0000;
    cur_exp = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Idle scanning, no keys.
    reset_dut();
    repeat (3) run_frame(16'h0000);

    // Row 1 / column 2 held from the first frame.
    reset_dut();
    repeat (4) run_frame(16'h0040);

    // Reset during column 2 while psw = 0x0040, then re-debounce.
    keys = 16'h0040;
    repeat (9) tick();
    reset_dut();
    repeat (3) run_frame(16'h0040);
    repeat (3) run_frame(16'h0000);

    // Bouncing key (0,0): present, absent, then stable.
    run_frame(16'h0001);
    run_frame(16'h0000);
    repeat (3) run_frame(16'h0001);
    repeat (3) run_frame(16'h0000);

    // Two keys together, then release.
    repeat (3) run_frame(16'h8001);
    repeat (3) run_frame(16'h0000);

    // Pick up the last frame's result.
    tick();
    check("sb_drained", 16'(sb.size()), 16'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keyscan.md
KEYSCAN -- requirements
Module: keyscan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 8: consecutive identical full frames required before psw updates; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 row  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 psw  output  16  debounced key state; bit (r*4+c) high = key at row r, column c pressed.
REQ-008 psw_chg  output  1  one-cycle pulse in the cycle psw takes a new, different value.

Function
REQ-009 Row inputs SHALL pass through a 2-flop synchronizer before use.
REQ-010 Column pointer cidx (0..3) SHALL drive col = ~(4'b0001 << cidx).
REQ-011 Dwell counter SHALL count 0..SCAN_DIV-1 per column; at SCAN_DIV-1 it wraps to 0 and cidx advances (3 wraps to 0).
REQ-012 Row sampling SHALL occur only on the dwell cycle SCAN_DIV-1, so synchronizer latency and line settling elapse first.
REQ-013 On sampling, frame bits [r*4+cidx] SHALL load ~row_sync[r] for r = 0..3.
REQ-014 Frame completes on the sample of cidx = 3; one frame = 4*SCAN_DIV cycles.
REQ-015 At frame completion, if the new frame equals the previous completed frame, the stable counter increments, saturating at DEBOUNCE_SCANS; otherwise it clears to 0.
REQ-016 The first completed frame after reset SHALL compare against an all-zero previous frame.
REQ-017 When the stable counter reaches DEBOUNCE_SCANS-1 on an increment (or DEBOUNCE_SCANS = 1 on any completion), psw SHALL load the frame on the next edge.
REQ-018 psw_chg SHALL assert in the same cycle psw changes, only if the new value differs from the old.
REQ-019 Latency: psw changes 1 cycle after the completing sample of the DEBOUNCE_SCANS-th identical frame.
REQ-020 Multiple simultaneous keys SHALL be reported as-is; ghosting is not resolved.
REQ-021 A frame differing from its predecessor SHALL NOT alter psw; it restarts the debounce count.
REQ-022 Counters SHALL NOT overflow; the stable counter is clog2(DEBOUNCE_SCANS+1) bits wide.

Reset
REQ-023 rst high SHALL set: cidx = 0 (col = 4'b1110), dwell counter 0, synchronizer flops 4'hF, frame and previous frame 0, stable counter 0, psw 16'h0000, psw_chg 0.
REQ-024 rst mid-frame SHALL discard the partial frame; scanning restarts at column 0 on the first cycle after rst deasserts.

Structure
REQ-025 Package keyscan_pkg SHALL hold NUM_ROWS = 4, NUM_COLS = 4, KEY_W = 16, and the default SCAN_DIV and DEBOUNCE_SCANS values.
REQ-026 The row synchronizer SHALL be a sub-module sync2 (parameterized width, reset value); all other logic stays in keyscan.
REQ-027 psw SHALL feed the downstream keypad encoder unchanged; its encoding is one bit per key, not binary.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 3, frame = 16 cycles)
REQ-028 Reset, then no keys -> col cycles 1110, 1101, 1011, 0111, every 4 cycles; psw = 0; psw_chg never asserts.
REQ-029 Model holds row1 low while col2 low from the first frame -> psw = 16'h0040 with a one-cycle psw_chg, 1 cycle after the third completed frame's final sample.
REQ-030 Key row0/col0 bounces, present in frames 1 and 3 and absent in frame 2, then stable -> psw updates only after 3 identical consecutive frames (frames 3, 4, 5).
REQ-031 Keys (0,0) and (3,3) pressed together -> psw = 16'h8001; releasing both -> psw = 0 after 3 clean frames, with psw_chg pulses at each transition.
REQ-032 rst asserted during column 2 with psw = 16'h0040 -> next cycle psw = 0, col = 1110; re-debounce needs 3 full frames.
